// File: rtl/multi_adder_display_if.sv
// Touchscreen/display link between lcd_module (master) and the adder display block (slave).
interface multi_adder_display_if;
    logic        input_valid;
    logic [31:0] input_value;
    logic [5:0]  display_number;
    logic        display_valid;
    logic [39:0] display_name;
    logic [31:0] display_value;

    modport master (
        output input_valid, input_value, display_number,
        input  display_valid, display_name, display_value
    );

    modport slave (
        input  input_valid, input_value, display_number,
        output display_valid, display_name, display_value
    );
endinterface

// File: rtl/multi_adder_display.sv
// NUM_OPS-operand adder, CHUNK bits per cycle, with carry-in and overflow count;
// operands, result, overflow count and FSM status are published to lcd_module.
module multi_adder_display #(
    parameter int WIDTH   = 32,
    parameter int NUM_OPS = 4,
    parameter int CHUNK   = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [2:0]           input_sel,
    input  logic                 sw_cin,
    input  logic                 sw_start,
    output logic                 led_busy,
    output logic                 led_done,
    output logic                 led_cout,
    multi_adder_display_if.slave lcd
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int OW     = $clog2(NUM_OPS);
    localparam int OVW    = $clog2(NUM_OPS + 1);
    localparam int SW     = CHUNK + 1;
    localparam logic [WIDTH-1:0] CMASK = WIDTH'((33'd1 << CHUNK) - 33'd1);
    localparam logic [3:0] NOPS        = 4'(NUM_OPS);
    localparam logic [5:0] SLOT_OPEND  = 6'(NUM_OPS);
    localparam logic [5:0] SLOT_RES    = 6'(NUM_OPS + 1);
    localparam logic [5:0] SLOT_OVF    = 6'(NUM_OPS + 2);
    localparam logic [5:0] SLOT_STATE  = 6'(NUM_OPS + 3);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] op [NUM_OPS];
    logic [WIDTH-1:0] acc, acc_nxt, result;
    logic [OVW-1:0]   ovf, ovf_nxt, ovf_res;
    logic             carry;
    logic [OW-1:0]    op_idx, slot_k;
    logic [CW-1:0]    chunk_idx;
    logic             start_q, start_edge, load_en, run_entry;
    logic             last_chunk, last_op;
    logic [31:0]      bit_lo;
    logic [CHUNK-1:0] acc_chunk, op_chunk, sum_s;
    logic             sum_c;
    logic             disp_valid_nxt;
    logic [39:0]      disp_name_nxt;
    logic [31:0]      disp_value_nxt;
    logic             unused_in;

    // Touchscreen bits above WIDTH are dropped on load.
    assign unused_in  = ^lcd.input_value;

    assign start_edge = sw_start & ~start_q;
    assign load_en    = lcd.input_valid && (state != RUN) && ({1'b0, input_sel} < NOPS);
    assign run_entry  = (state != RUN) && start_edge;
    assign last_chunk = (chunk_idx == CW'(NCHUNK - 1));
    assign last_op    = (op_idx == OW'(NUM_OPS - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A start edge in DONE takes priority over a simultaneous operand load.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_edge) state_nxt = RUN;
            RUN:     if (last_chunk && last_op) state_nxt = DONE;
            DONE: begin
                if (start_edge)   state_nxt = RUN;
                else if (load_en) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bit_lo         = 32'(chunk_idx) * 32'(CHUNK);
        acc_chunk      = CHUNK'(acc >> bit_lo);
        op_chunk       = CHUNK'(op[op_idx] >> bit_lo);
        {sum_c, sum_s} = {1'b0, acc_chunk} + {1'b0, op_chunk} + SW'(carry);
        acc_nxt        = (acc & ~(CMASK << bit_lo)) | (WIDTH'(sum_s) << bit_lo);
        ovf_nxt        = ovf + OVW'(sum_c);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_OPS; i++) op[i] <= '0;
        end else if (load_en) begin
            op[input_sel[OW-1:0]] <= lcd.input_value[WIDTH-1:0];
        end
    end

    // Carry ripples between chunks of one operand; the chunk carry-out of the
    // top chunk goes to the overflow counter instead.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            start_q   <= 1'b0;
            acc       <= '0;
            carry     <= 1'b0;
            ovf       <= '0;
            op_idx    <= '0;
            chunk_idx <= '0;
            result    <= '0;
            ovf_res   <= '0;
        end else begin
            start_q <= sw_start;
            if (run_entry) begin
                acc       <= '0;
                carry     <= sw_cin;
                ovf       <= '0;
                op_idx    <= '0;
                chunk_idx <= '0;
            end else if (state == RUN) begin
                acc <= acc_nxt;
                if (last_chunk) begin
                    ovf       <= ovf_nxt;
                    carry     <= 1'b0;
                    chunk_idx <= '0;
                    op_idx    <= last_op ? '0 : op_idx + OW'(1);
                    if (last_op) begin
                        result  <= acc_nxt;
                        ovf_res <= ovf_nxt;
                    end
                end else begin
                    carry     <= sum_c;
                    chunk_idx <= chunk_idx + CW'(1);
                end
            end
        end
    end

    always_comb begin
        disp_valid_nxt = 1'b0;
        disp_name_nxt  = '0;
        disp_value_nxt = '0;
        slot_k         = OW'(lcd.display_number - 6'd1);
        if (lcd.display_number >= 6'd1 && lcd.display_number <= SLOT_OPEND) begin
            disp_valid_nxt = 1'b1;
            disp_name_nxt  = {"OP_", 8'h30 + 8'(slot_k), " "};
            disp_value_nxt = 32'(op[slot_k]);
        end else if (lcd.display_number == SLOT_RES) begin
            disp_valid_nxt = 1'b1;
            disp_name_nxt  = "RESUL";
            disp_value_nxt = 32'(result);
        end else if (lcd.display_number == SLOT_OVF) begin
            disp_valid_nxt = 1'b1;
            disp_name_nxt  = "OVFCN";
            disp_value_nxt = 32'(ovf_res);
        end else if (lcd.display_number == SLOT_STATE) begin
            disp_valid_nxt = 1'b1;
            disp_name_nxt  = "STATE";
            disp_value_nxt = {state, 14'd0, 8'(op_idx), 8'(chunk_idx)};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lcd.display_valid <= 1'b0;
            lcd.display_name  <= '0;
            lcd.display_value <= '0;
        end else begin
            lcd.display_valid <= disp_valid_nxt;
            lcd.display_name  <= disp_name_nxt;
            lcd.display_value <= disp_value_nxt;
        end
    end

    assign led_busy = (state != RUN);
    assign led_done = (state != DONE);
    assign led_cout = (ovf_res == '0);
endmodule

// File: tb/tb_multi_adder_display.sv
// Directed bench for multi_adder_display: default instance plus a WIDTH=16/NUM_OPS=8/CHUNK=4 instance.
module tb_multi_adder_display;
    logic clk = 1'b0;
    always #50 clk = ~clk;

    logic       resetn;
    logic [2:0] sel_a, sel_b;
    logic       cin_a, cin_b, start_a, start_b;
    logic       busy_a, done_a, cout_a, busy_b, done_b, cout_b;

    multi_adder_display_if ifa ();
    multi_adder_display_if ifb ();

    multi_adder_display dut_a (
        .clk(clk), .resetn(resetn), .input_sel(sel_a), .sw_cin(cin_a), .sw_start(start_a),
        .led_busy(busy_a), .led_done(done_a), .led_cout(cout_a), .lcd(ifa)
    );

    multi_adder_display #(.WIDTH(16), .NUM_OPS(8), .CHUNK(4)) dut_b (
        .clk(clk), .resetn(resetn), .input_sel(sel_b), .sw_cin(cin_b), .sw_start(start_b),
        .led_busy(busy_b), .led_done(done_b), .led_cout(cout_b), .lcd(ifb)
    );

    int          checks = 0;
    int          failures = 0;
    logic [63:0] sb_q[$];
    logic [31:0] mdl_a [4];
    logic [15:0] mdl_b [8];
    logic [31:0] last_res;
    logic [31:0] last_ovf;

    localparam logic [39:0] N_RES   = 40'h5245_53554C;
    localparam logic [39:0] N_OVF   = 40'h4F56_46434E;
    localparam logic [39:0] N_STATE = 40'h5354_415445;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_chk(input string tag, input logic [63:0] obs);
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s scoreboard empty observed=0x%0h expected=<none>", tag, obs);
        end else begin
            chk(tag, obs, sb_q.pop_front());
        end
    endtask

    function automatic logic [39:0] ename(input int slot, input int nops);
        logic [7:0] d;
        d = 8'(48 + slot - 1);
        if (slot >= 1 && slot <= nops) return {24'h4F505F, d, 8'h20};
        if (slot == nops + 1) return N_RES;
        if (slot == nops + 2) return N_OVF;
        if (slot == nops + 3) return N_STATE;
        return 40'h0;
    endfunction

    task automatic rd_a(input int slot, input logic [63:0] ev, input logic [63:0] en,
                        input logic [63:0] eval, input logic [31:0] mask);
        ifa.display_number = 6'(slot);
        sb_q.push_back(ev);
        sb_q.push_back(en);
        sb_q.push_back(eval & 64'(mask));
        tick();
        sb_chk($sformatf("a_slot%0d_valid", slot), 64'(ifa.display_valid));
        sb_chk($sformatf("a_slot%0d_name", slot), 64'(ifa.display_name));
        sb_chk($sformatf("a_slot%0d_value", slot), 64'(ifa.display_value & mask));
    endtask

    task automatic load_a(input logic [2:0] sel, input logic [31:0] val, input bit effective);
        sel_a = sel;
        ifa.input_value = val;
        ifa.input_valid = 1'b1;
        tick();
        ifa.input_valid = 1'b0;
        if (effective) mdl_a[sel[1:0]] = val;
    endtask

    task automatic run_a(input bit mid_load, input bit with_load, input logic [31:0] lval);
        logic [63:0] tot;
        int n;
        if (with_load) begin
            sel_a = 3'd0;
            ifa.input_value = lval;
            ifa.input_valid = 1'b1;
            mdl_a[0] = lval;
        end
        tot = 64'(cin_a);
        for (int i = 0; i < 4; i++) tot += 64'(mdl_a[i]);
        last_res = tot[31:0];
        last_ovf = 32'(tot >> 32);
        sb_q.push_back(64'(last_res));
        sb_q.push_back(64'(last_ovf));
        start_a = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            ifa.input_valid = 1'b0;
            if (n == 1) chk("a_busy_in_run", 64'(busy_a), 64'd0);
            if (mid_load && n == 3) begin
                sel_a = 3'd0;
                ifa.input_value = 32'h55;
                ifa.input_valid = 1'b1;
            end
        end while (done_a !== 1'b0 && n < 200);
        chk("a_run_len", 64'(n), 64'd17);
        repeat (3) tick();
        chk("a_single_run", 64'({busy_a, done_a}), 64'b10);
        start_a = 1'b0;
        tick();
        ifa.display_number = 6'd5;
        tick();
        sb_chk("a_result", 64'(ifa.display_value));
        ifa.display_number = 6'd6;
        tick();
        sb_chk("a_ovfcn", 64'(ifa.display_value));
        chk("a_led_cout", 64'(cout_a), (last_ovf != 0) ? 64'd0 : 64'd1);
    endtask

    task automatic run_b(input int r);
        logic [63:0] tot;
        logic [31:0] v;
        int n;
        for (int i = 0; i < 8; i++) begin
            v = (r == 0) ? 32'hFFFF_FFFF : (r == 1) ? 32'h0 : $urandom;
            sel_b = 3'(i);
            ifb.input_value = v;
            ifb.input_valid = 1'b1;
            mdl_b[i] = v[15:0];
            tick();
        end
        ifb.input_valid = 1'b0;
        cin_b = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        tot = 64'(cin_b);
        for (int i = 0; i < 8; i++) tot += 64'(mdl_b[i]);
        sb_q.push_back(64'(tot[15:0]));
        sb_q.push_back(tot >> 16);
        start_b = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (done_b !== 1'b0 && n < 300);
        chk($sformatf("b_run%0d_len", r), 64'(n), 64'd33);
        start_b = 1'b0;
        ifb.display_number = 6'd9;
        tick();
        sb_chk($sformatf("b_run%0d_result", r), 64'(ifb.display_value));
        ifb.display_number = 6'd10;
        tick();
        sb_chk($sformatf("b_run%0d_ovf", r), 64'(ifb.display_value));
        chk($sformatf("b_run%0d_cout", r), 64'(cout_b), ((tot >> 16) != 0) ? 64'd0 : 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        lastn_v;
        logic [39:0] lastn;
        logic [63:0] ev;
        logic [31:0] mask;

        resetn = 1'b0;
        {sel_a, sel_b, cin_a, cin_b, start_a, start_b} = '0;
        ifa.input_valid = 1'b0; ifa.input_value = '0; ifa.display_number = 6'd1;
        ifb.input_valid = 1'b0; ifb.input_value = '0; ifb.display_number = 6'd1;
        for (int i = 0; i < 4; i++) mdl_a[i] = '0;
        repeat (2) tick();
        chk("rst_leds", 64'({busy_a, done_a, cout_a}), 64'b111);
        chk("rst_disp_valid", 64'(ifa.display_valid), 64'd0);
        chk("rst_disp_name", 64'(ifa.display_name), 64'd0);
        chk("rst_disp_value", 64'(ifa.display_value), 64'd0);
        resetn = 1'b1;
        tick();

        // Basic sum with defaults
        load_a(3'd0, 32'd1, 1'b1);
        load_a(3'd1, 32'd2, 1'b1);
        load_a(3'd2, 32'd3, 1'b1);
        load_a(3'd3, 32'd4, 1'b1);
        rd_a(1, 64'd1, 64'(ename(1, 4)), 64'd1, 32'hFFFF_FFFF);
        run_a(1'b0, 1'b0, 32'h0);
        chk("basic_result_model", 64'(last_res), 64'h0000_000A);

        // Display sweep in DONE; each request must not be visible before the next edge
        lastn_v = 1'b1;
        lastn = N_OVF;
        for (int s = 1; s <= 44; s++) begin
            ifa.display_number = 6'(s);
            #1;
            chk($sformatf("a_lag%0d_name", s), 64'(ifa.display_name), 64'(lastn));
            mask = 32'hFFFF_FFFF;
            if (s <= 4)      ev = 64'(mdl_a[s-1]);
            else if (s == 5) ev = 64'(last_res);
            else if (s == 6) ev = 64'(last_ovf);
            else if (s == 7) begin ev = 64'h8000_0000; mask = 32'hC000_0000; end
            else             ev = 64'd0;
            rd_a(s, (s <= 7) ? 64'd1 : 64'd0, 64'(ename(s, 4)), ev, mask);
            lastn_v = (s <= 7);
            lastn = ename(s, 4);
        end
        chk("sweep_last_invalid", 64'(lastn_v), 64'd0);

        // Overflow; first load in DONE drops back to IDLE
        load_a(3'd0, 32'hFFFF_FFFF, 1'b1);
        chk("load_in_done_idle", 64'({busy_a, done_a}), 64'b11);
        load_a(3'd1, 32'hFFFF_FFFF, 1'b1);
        load_a(3'd2, 32'hFFFF_FFFF, 1'b1);
        load_a(3'd3, 32'hFFFF_FFFF, 1'b1);
        cin_a = 1'b1;
        run_a(1'b0, 1'b0, 32'h0);

        // Out-of-range input_sel in DONE changes nothing
        load_a(3'd5, 32'h0000_DEAD, 1'b0);
        chk("sel5_stays_done", 64'(done_a), 64'd0);
        for (int s = 1; s <= 4; s++) rd_a(s, 64'd1, 64'(ename(s, 4)), 64'(mdl_a[s-1]), 32'hFFFF_FFFF);

        // Load in DONE -> IDLE
        load_a(3'd1, 32'd7, 1'b1);
        chk("load_done_led", 64'(done_a), 64'd1);
        rd_a(7, 64'd1, 64'(N_STATE), 64'h0, 32'hC000_0000);
        rd_a(2, 64'd1, 64'(ename(2, 4)), 64'd7, 32'hFFFF_FFFF);

        // Load during RUN ignored, then load together with edge in DONE
        run_a(1'b1, 1'b0, 32'h0);
        rd_a(1, 64'd1, 64'(ename(1, 4)), 64'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_a(1'b0, 1'b1, 32'h100);
        chk("load_edge_result", 64'(last_res), 64'h106);
        rd_a(1, 64'd1, 64'(ename(1, 4)), 64'h100, 32'hFFFF_FFFF);

        // Asynchronous reset at run step 5
        start_a = 1'b1;
        tick();
        chk("rstrun_busy", 64'(busy_a), 64'd0);
        repeat (5) tick();
        #20 resetn = 1'b0;
        #1;
        chk("rstrun_leds", 64'({busy_a, done_a, cout_a}), 64'b111);
        chk("rstrun_valid", 64'(ifa.display_valid), 64'd0);
        chk("rstrun_name", 64'(ifa.display_name), 64'd0);
        chk("rstrun_value", 64'(ifa.display_value), 64'd0);
        start_a = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        for (int i = 0; i < 4; i++) mdl_a[i] = '0;
        rd_a(5, 64'd1, 64'(N_RES), 64'd0, 32'hFFFF_FFFF);
        rd_a(1, 64'd1, 64'(ename(1, 4)), 64'd0, 32'hFFFF_FFFF);
        rd_a(7, 64'd1, 64'(N_STATE), 64'd0, 32'hFFFF_FFFF);

        // Parameter sweep instance
        for (int r = 0; r < 50; r++) run_b(r);

        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
